// File: rtl/int_addsub_pipe.sv
// Pipelined integer add/subtract unit with tag tracking, status flags,
// elastic backpressure toward the CDB and single-cycle flush.
module int_addsub_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sub,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    logic [WIDTH-1:0]  w_bx;
    logic [WIDTH:0]    w_sum;
    logic              w_ovf;
    logic              w_take;
    logic              w_accept;
    logic [STAGES-1:0] w_adv;

    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  r_result [STAGES];
    logic              r_carry  [STAGES];
    logic              r_ovf    [STAGES];
    logic              r_zero   [STAGES];
    logic [TAG_W-1:0]  r_tag    [STAGES];

    // Subtract is A + ~B + 1; the carry-in comes from the mode bit.
    assign w_bx  = in_b ^ {WIDTH{in_sub}};
    assign w_sum = {1'b0, in_a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, in_sub};
    assign w_ovf = (in_a[WIDTH-1] == w_bx[WIDTH-1]) & (w_sum[WIDTH-1] != in_a[WIDTH-1]);

    // A stage may load when it, or any stage after it, is empty, or the CDB drains.
    always_comb begin
        w_adv = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_adv[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!r_valid[j]) begin
                    w_adv[k] = 1'b1;
                end
            end
        end
    end

    assign in_ready = w_adv[0] | flush;
    assign w_take   = in_valid & in_ready;
    assign w_accept = w_take & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_result[k] <= '0;
                r_carry[k]  <= 1'b0;
                r_ovf[k]    <= 1'b0;
                r_zero[k]   <= 1'b0;
                r_tag[k]    <= '0;
            end
        end else begin
            if (w_adv[0]) begin
                r_valid[0] <= w_accept;
                if (w_take) begin
                    r_result[0] <= w_sum[WIDTH-1:0];
                    r_carry[0]  <= w_sum[WIDTH];
                    r_ovf[0]    <= w_ovf;
                    r_zero[0]   <= (w_sum[WIDTH-1:0] == '0);
                    r_tag[0]    <= in_tag;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (w_adv[k]) begin
                    r_valid[k] <= r_valid[k-1];
                    if (r_valid[k-1]) begin
                        r_result[k] <= r_result[k-1];
                        r_carry[k]  <= r_carry[k-1];
                        r_ovf[k]    <= r_ovf[k-1];
                        r_zero[k]   <= r_zero[k-1];
                        r_tag[k]    <= r_tag[k-1];
                    end
                end
            end
            // Squash overrides every load above; payload registers keep stale data.
            if (flush) begin
                r_valid <= '0;
            end
        end
    end

    assign out_valid  = r_valid[STAGES-1];
    assign out_result = r_result[STAGES-1];
    assign out_carry  = r_carry[STAGES-1];
    assign out_ovf    = r_ovf[STAGES-1];
    assign out_zero   = r_zero[STAGES-1];
    assign out_tag    = r_tag[STAGES-1];

endmodule

// File: tb/tb_int_addsub_pipe.sv
// Drives three configurations (32/2, 8/1, 64/4) of int_addsub_pipe and
// checks them against an arithmetic reference model and per-unit scoreboard.
module tb_int_addsub_pipe;

    localparam int WID [3] = '{32, 8, 64};
    localparam int STG [3] = '{2, 1, 4};

    typedef struct {
        int          id;
        logic [63:0] res;
        logic        carry;
        logic        ovf;
        logic        zero;
        logic [3:0]  tag;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        ordy;
    logic        iv   [3];
    logic        isub [3];
    logic [63:0] ia   [3];
    logic [63:0] ib   [3];
    logic [3:0]  itag [3];
    logic        irdy [3];
    logic        ov   [3];
    logic        oc   [3];
    logic        oo   [3];
    logic        oz   [3];
    logic [3:0]  ot   [3];
    logic [63:0] ores [3];
    logic [31:0] res32;
    logic [7:0]  res8;
    logic [63:0] res64;

    int   checks;
    int   errors;
    exp_t q[$];
    bit   acc [3];
    int   del [3];
    int   nt  [3];
    logic [63:0] va [7];
    logic [63:0] vb [7];
    logic        vs [7];

    assign ores[0] = 64'(res32);
    assign ores[1] = 64'(res8);
    assign ores[2] = res64;

    int_addsub_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(4)) u_w32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv[0]), .in_ready(irdy[0]), .in_sub(isub[0]),
        .in_a(ia[0][31:0]), .in_b(ib[0][31:0]), .in_tag(itag[0]),
        .out_valid(ov[0]), .out_ready(ordy), .out_result(res32),
        .out_carry(oc[0]), .out_ovf(oo[0]), .out_zero(oz[0]), .out_tag(ot[0])
    );

    int_addsub_pipe #(.WIDTH(8), .STAGES(1), .TAG_W(4)) u_w8 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv[1]), .in_ready(irdy[1]), .in_sub(isub[1]),
        .in_a(ia[1][7:0]), .in_b(ib[1][7:0]), .in_tag(itag[1]),
        .out_valid(ov[1]), .out_ready(ordy), .out_result(res8),
        .out_carry(oc[1]), .out_ovf(oo[1]), .out_zero(oz[1]), .out_tag(ot[1])
    );

    int_addsub_pipe #(.WIDTH(64), .STAGES(4), .TAG_W(4)) u_w64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv[2]), .in_ready(irdy[2]), .in_sub(isub[2]),
        .in_a(ia[2]), .in_b(ib[2]), .in_tag(itag[2]),
        .out_valid(ov[2]), .out_ready(ordy), .out_result(res64),
        .out_carry(oc[2]), .out_ovf(oo[2]), .out_zero(oz[2]), .out_tag(ot[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Reference: plain modular and signed-integer arithmetic at the unit's width.
    function automatic exp_t model(input int x, input logic sub, input logic [63:0] a_in,
                                   input logic [63:0] b_in, input logic [3:0] tag);
        exp_t               e;
        int                 w;
        logic [64:0]        mask;
        logic [64:0]        a;
        logic [64:0]        b;
        logic [64:0]        full;
        logic signed [66:0] sa;
        logic signed [66:0] sb;
        logic signed [66:0] r;
        logic signed [66:0] lim;
        w    = WID[x];
        mask = (65'd1 << w) - 65'd1;
        a    = {1'b0, a_in} & mask;
        b    = {1'b0, b_in} & mask;
        if (!sub) begin
            full    = a + b;
            e.carry = (full > mask);
        end else begin
            full    = a - b;
            e.carry = (a >= b);
        end
        e.res  = 64'(full & mask);
        e.zero = (e.res == 64'd0);
        lim = 67'sd1 <<< (w - 1);
        sa  = $signed({2'b00, a});
        sb  = $signed({2'b00, b});
        if (a[w-1]) sa = sa - (lim <<< 1);
        if (b[w-1]) sb = sb - (lim <<< 1);
        r      = sub ? (sa - sb) : (sa + sb);
        e.ovf  = (r >= lim) || (r < -lim);
        e.id   = x;
        e.tag  = tag;
        return e;
    endfunction

    // One clock: score handshakes just before the edge, then advance.
    task automatic tick();
        int   held [3];
        int   idx;
        exp_t e;
        #1;
        for (int x = 0; x < 3; x++) acc[x] = 1'b0;
        if (rst) begin
            q.delete();
        end else begin
            for (int x = 0; x < 3; x++) begin
                held[x] = 0;
                for (int i = 0; i < q.size(); i++) if (q[i].id == x) held[x]++;
                chk($sformatf("in_ready d%0d", x), 64'(irdy[x]),
                    64'(flush || ordy || (held[x] < STG[x])));
            end
            for (int x = 0; x < 3; x++) begin
                if (ov[x] && ordy) begin
                    idx = -1;
                    for (int i = 0; i < q.size(); i++) if (idx < 0 && q[i].id == x) idx = i;
                    chk($sformatf("expected_op d%0d", x), 64'(idx >= 0), 64'd1);
                    if (idx >= 0) begin
                        e = q[idx];
                        q.delete(idx);
                        del[x]++;
                        chk($sformatf("tag d%0d", x), 64'(ot[x]), 64'(e.tag));
                        chk($sformatf("result d%0d", x), ores[x], e.res);
                        chk($sformatf("carry d%0d", x), 64'(oc[x]), 64'(e.carry));
                        chk($sformatf("ovf d%0d", x), 64'(oo[x]), 64'(e.ovf));
                        chk($sformatf("zero d%0d", x), 64'(oz[x]), 64'(e.zero));
                    end
                end
            end
            if (flush) begin
                q.delete();
            end else begin
                for (int x = 0; x < 3; x++) begin
                    if (iv[x] && irdy[x]) begin
                        q.push_back(model(x, isub[x], ia[x], ib[x], itag[x]));
                        acc[x] = 1'b1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_chk(input string name);
        for (int x = 0; x < 3; x++) begin
            chk($sformatf("%s out_valid d%0d", name, x), 64'(ov[x]), 64'd0);
            chk($sformatf("%s out_result d%0d", name, x), ores[x], 64'd0);
            chk($sformatf("%s out_carry d%0d", name, x), 64'(oc[x]), 64'd0);
            chk($sformatf("%s out_ovf d%0d", name, x), 64'(oo[x]), 64'd0);
            chk($sformatf("%s out_zero d%0d", name, x), 64'(oz[x]), 64'd0);
            chk($sformatf("%s out_tag d%0d", name, x), 64'(ot[x]), 64'd0);
            chk($sformatf("%s in_ready d%0d", name, x), 64'(irdy[x]), 64'd1);
        end
    endtask

    // Issue one op to every unit into an empty pipe and check exact latency.
    task automatic lat_run(input logic sub, input logic [63:0] a, input logic [63:0] b,
                           input logic [3:0] tag, input bit cc,
                           input logic [31:0] r32, input logic c32, input logic v32,
                           input logic z32, input logic [7:0] r8, input logic c8);
        ordy = 1'b1;
        for (int x = 0; x < 3; x++) begin
            iv[x] = 1'b1; isub[x] = sub; ia[x] = a; ib[x] = b; itag[x] = tag;
        end
        tick();
        for (int x = 0; x < 3; x++) iv[x] = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            for (int x = 0; x < 3; x++)
                chk($sformatf("latency d%0d c%0d", x, c), 64'(ov[x]), 64'(c == STG[x]));
            if (cc && c == STG[0]) begin
                chk("w32 result", ores[0], 64'(r32));
                chk("w32 carry", 64'(oc[0]), 64'(c32));
                chk("w32 ovf", 64'(oo[0]), 64'(v32));
                chk("w32 zero", 64'(oz[0]), 64'(z32));
                chk("w32 tag", 64'(ot[0]), 64'(tag));
            end
            if (cc && c == STG[1]) begin
                chk("w8 result", ores[1], 64'(r8));
                chk("w8 carry", 64'(oc[1]), 64'(c8));
            end
            tick();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; flush = 1'b0; ordy = 1'b1;
        for (int x = 0; x < 3; x++) begin
            iv[x] = 1'b0; isub[x] = 1'b0; ia[x] = '0; ib[x] = '0; itag[x] = '0; del[x] = 0;
        end
        tick();
        tick();
        rst = 1'b0;
        reset_chk("reset");

        // Directed arithmetic and flag corners.
        lat_run(1'b0, 64'h5,        64'h3,  4'd2, 1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 8'h08, 1'b0);
        lat_run(1'b1, 64'h3,        64'h5,  4'd3, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 8'hFE, 1'b0);
        lat_run(1'b1, 64'h1234,     64'h1234, 4'd4, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
        lat_run(1'b0, 64'h7FFF_FFFF, 64'h1, 4'd5, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        lat_run(1'b0, 64'hFFFF_FFFF, 64'h1, 4'd6, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
        lat_run(1'b0, 64'hF0,       64'h20, 4'd7, 1'b1, 32'h0000_0110, 1'b0, 1'b0, 1'b0, 8'h10, 1'b1);
        lat_run(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 4'd8, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);

        // Back-to-back tags 1..6, CDB stalled for six cycles from the third.
        for (int t = 1; t <= 6; t++) begin
            va[t] = {$urandom(), $urandom()}; vb[t] = {$urandom(), $urandom()}; vs[t] = 1'($urandom());
        end
        for (int x = 0; x < 3; x++) begin nt[x] = 1; del[x] = 0; end
        for (int cyc = 0; cyc < 30; cyc++) begin
            ordy = !(cyc >= 2 && cyc < 8);
            for (int x = 0; x < 3; x++) begin
                int t;
                t = (nt[x] <= 6) ? nt[x] : 1;
                iv[x] = (nt[x] <= 6); itag[x] = 4'(t); ia[x] = va[t]; ib[x] = vb[t]; isub[x] = vs[t];
                if (cyc == 7) chk($sformatf("full in_ready d%0d", x), 64'(irdy[x]), 64'd0);
                if (cyc >= 8 && del[x] < 6) chk($sformatf("throughput d%0d", x), 64'(ov[x]), 64'd1);
            end
            tick();
            for (int x = 0; x < 3; x++) if (acc[x]) nt[x]++;
        end
        for (int x = 0; x < 3; x++) begin
            iv[x] = 1'b0;
            chk($sformatf("stall issued d%0d", x), 64'(nt[x]), 64'd7);
            chk($sformatf("stall delivered d%0d", x), 64'(del[x]), 64'd6);
        end

        // Random traffic with random backpressure and occasional flush.
        for (int n = 0; n < 400; n++) begin
            ordy  = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 24) == 0);
            for (int x = 0; x < 3; x++) begin
                iv[x] = 1'($urandom()); isub[x] = 1'($urandom()); itag[x] = 4'($urandom());
                ia[x] = {$urandom(), $urandom()}; ib[x] = {$urandom(), $urandom()};
                case ($urandom_range(0, 3))
                    0: ib[x] = ia[x];
                    1: begin ia[x] = 64'hFFFF_FFFF_FFFF_FFFF >> $urandom_range(0, 63); ib[x] = 64'h1; end
                    default: ;
                endcase
            end
            tick();
        end
        flush = 1'b0; ordy = 1'b1;
        for (int x = 0; x < 3; x++) iv[x] = 1'b0;
        for (int n = 0; n < 8; n++) tick();
        chk("drained", 64'(q.size()), 64'd0);

        // Flush with ops in flight plus a same-cycle issue.
        ordy = 1'b0;
        for (int n = 0; n < 2; n++) begin
            for (int x = 0; x < 3; x++) begin
                iv[x] = 1'b1; isub[x] = 1'b0; itag[x] = 4'(n + 1);
                ia[x] = {$urandom(), $urandom()}; ib[x] = {$urandom(), $urandom()};
            end
            tick();
        end
        flush = 1'b1;
        for (int x = 0; x < 3; x++) itag[x] = 4'd9;
        tick();
        flush = 1'b0;
        for (int x = 0; x < 3; x++) begin
            iv[x] = 1'b0;
            chk($sformatf("post-flush out_valid d%0d", x), 64'(ov[x]), 64'd0);
        end
        lat_run(1'b1, 64'h0000_0000_0000_0010, 64'h0000_0000_0000_0001, 4'd10, 1'b1,
                32'h0000_000F, 1'b1, 1'b0, 1'b0, 8'h0F, 1'b1);

        // Reset with ops in flight discards them.
        ordy = 1'b0;
        for (int n = 0; n < 3; n++) begin
            for (int x = 0; x < 3; x++) begin
                iv[x] = 1'b1; itag[x] = 4'(n + 11); ia[x] = {$urandom(), $urandom()}; ib[x] = 64'h1;
            end
            tick();
        end
        rst = 1'b1;
        for (int x = 0; x < 3; x++) iv[x] = 1'b0;
        tick();
        rst = 1'b0;
        ordy = 1'b1;
        reset_chk("midreset");
        for (int n = 0; n < 6; n++) begin
            for (int x = 0; x < 3; x++)
                chk($sformatf("midreset quiet d%0d", x), 64'(ov[x]), 64'd0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
